// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO byte staging with
// full-stall buffering, and running-parity check against the trailing byte.
module router_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             packet_valid,
    input  logic [WIDTH-1:0] data,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             lp_state,
    input  logic             reset_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_packet_valid,
    output logic             err
);

    logic [WIDTH-1:0] header_byte;
    logic [WIDTH-1:0] full_state_byte;
    logic [WIDTH-1:0] internal_parity;
    logic [WIDTH-1:0] packet_parity;
    logic             parity_done_q;

    // The parity-check state carries no datapath role in this stage.
    logic unused_lp_state;
    assign unused_lp_state = lp_state;

    // Header capture; address 3 is not a valid destination.
    always_ff @(posedge clock) begin
        if (reset) begin
            header_byte <= '0;
        end else if (detect_add && packet_valid && (data[1:0] != 2'b11)) begin
            header_byte <= data;
        end
    end

    // Output byte staging; a byte arriving against a full FIFO is parked
    // in full_state_byte and replayed once on laf_state.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout            <= '0;
            full_state_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data;
        end else if (ld_state && fifo_full) begin
            full_state_byte <= data;
        end else if (laf_state) begin
            dout <= full_state_byte;
        end
    end

    // Running parity over header and payload; the parity byte is excluded.
    always_ff @(posedge clock) begin
        if (reset) begin
            internal_parity <= '0;
        end else if (detect_add) begin
            internal_parity <= '0;
        end else if (lfd_state) begin
            internal_parity <= internal_parity ^ header_byte;
        end else if (ld_state && packet_valid && !full_state) begin
            internal_parity <= internal_parity ^ data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            packet_parity <= '0;
        end else if (detect_add) begin
            packet_parity <= '0;
        end else if (ld_state && !packet_valid) begin
            packet_parity <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !packet_valid) begin
            parity_done <= 1'b1;
        end else if (laf_state && low_packet_valid && !parity_done) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (reset_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !packet_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

    // err is evaluated once, on the cycle following the rise of parity_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_done_q <= 1'b0;
            err           <= 1'b0;
        end else begin
            parity_done_q <= parity_done;
            if (detect_add) begin
                err <= 1'b0;
            end else if (parity_done && !parity_done_q) begin
                err <= (internal_parity != packet_parity);
            end
        end
    end

endmodule
